uart_frame_sched: RTL and testbench

//  Sequences the 18-channel UART transmitter: OR-accumulates spike inputs over a fixed sampling

---
 rtl/uart_frame_sched.sv | 183 ++++++++++++++++++
 tb/tb_uart_frame_sched.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_sched.sv
// uart_frame_sched: frame scheduler in front of the 18-channel UART transmitter.
// OR-accumulates spike levels over a fixed window, snapshots the window into
// tx_frame at the boundary, pulses uart_start and waits for uart_done. A window
// that closes while the transmitter cannot take it is dropped and flagged.
// Optional feature: define UART_SCHED_WDT_EN to add the WAIT-state watchdog
// (timeout_err); without it WAIT lasts until uart_done and timeout_err is 0.
//
// Handshake: uart_start is a one-cycle launch strobe with tx_frame held stable
// while it is high; the transmitter answers with a one-cycle uart_done pulse,
// which is only honoured in WAIT. tx_busy is only looked at on an ACCUM boundary.
module uart_frame_sched #(
    parameter int unsigned CH_W        = 18,
    parameter int unsigned WIN_CYC     = 50000,
    parameter int unsigned TIMEOUT_CYC = 16384,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             sys_clk,
    input  logic             sys_reset,
    input  logic             en,
    input  logic             clr_status,
    input  logic [CH_W-1:0]  spike_in,
    input  logic             tx_busy,
    input  logic             uart_done,
    output logic             uart_start,
    output logic [CH_W-1:0]  tx_frame,
    output logic [CNT_W-1:0] frame_cnt,
    output logic             overrun,
    output logic             timeout_err,
    output logic [1:0]       sched_state
);

    localparam int unsigned WIN_W = $clog2(WIN_CYC);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCUM  = 2'd1;
    localparam logic [1:0] ST_LAUNCH = 2'd2;
    localparam logic [1:0] ST_WAIT   = 2'd3;

    // Reject parameter values the counters cannot represent.
    if (WIN_CYC < 4 || TIMEOUT_CYC < 2) begin : g_param_check
        $error("uart_frame_sched: WIN_CYC must be >= 4 and TIMEOUT_CYC >= 2");
    end

    logic [1:0]       state_q, state_d;
    logic [WIN_W-1:0] win_cnt_q, win_cnt_d;
    logic [CH_W-1:0]  acc_q, acc_d;
    logic [CH_W-1:0]  tx_frame_q, tx_frame_d;
    logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic             overrun_q, overrun_d;

    logic boundary;
    logic done_ok;
    logic wdt_fire;
    logic overrun_set;

    // Last cycle of the sampling window; never true while idle.
    assign boundary = (state_q != ST_IDLE) && (win_cnt_q == WIN_W'(WIN_CYC - 1));
    assign done_ok  = (state_q == ST_WAIT) && uart_done;

`ifdef UART_SCHED_WDT_EN
    localparam int unsigned WDT_W = $clog2(TIMEOUT_CYC);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             timeout_q, timeout_d;

    // uart_done on the final watchdog cycle counts as a normal completion.
    assign wdt_fire = (state_q == ST_WAIT) && !uart_done &&
                      (wdt_q == WDT_W'(TIMEOUT_CYC - 1));

    // Watchdog counts WAIT cycles from 0; timeout flag is sticky until cleared.
    always_comb begin
        wdt_d     = (state_q == ST_WAIT && state_d == ST_WAIT) ? wdt_q + 1'b1 : '0;
        timeout_d = (timeout_q & ~clr_status) | wdt_fire;
    end

    // Watchdog registers.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            wdt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            wdt_q     <= wdt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    assign wdt_fire    = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: en=0 in ACCUM wins over a boundary; LAUNCH/WAIT always finish.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en) state_d = ST_ACCUM;
            end
            ST_ACCUM: begin
                if (!en)                       state_d = ST_IDLE;
                else if (boundary && !tx_busy) state_d = ST_LAUNCH;
            end
            ST_LAUNCH: begin
                state_d = ST_WAIT;
            end
            default: begin
                if (done_ok || wdt_fire) state_d = en ? ST_ACCUM : ST_IDLE;
            end
        endcase
    end

    // FSM outputs: launch strobe for the single LAUNCH cycle, state for debug.
    always_comb begin
        uart_start  = (state_q == ST_LAUNCH);
        sched_state = state_q;
    end

    // Window counter, accumulator, frame snapshot, frame counter and overrun flag.
    always_comb begin
        win_cnt_d   = win_cnt_q;
        acc_d       = acc_q;
        tx_frame_d  = tx_frame_q;
        frame_cnt_d = frame_cnt_q;
        overrun_set = 1'b0;

        if (state_q == ST_IDLE || state_d == ST_IDLE) begin
            win_cnt_d = '0;
            acc_d     = '0;
        end else if (boundary) begin
            win_cnt_d = '0;
            acc_d     = '0;
        end else begin
            win_cnt_d = win_cnt_q + 1'b1;
            acc_d     = acc_q | spike_in;
        end

        if (boundary) begin
            if (state_q == ST_ACCUM) begin
                if (en && !tx_busy) tx_frame_d  = acc_q | spike_in;
                if (en && tx_busy)  overrun_set = 1'b1;
            end else begin
                // Transmitter still owns the previous frame: drop this window.
                overrun_set = 1'b1;
            end
        end

        if (done_ok) frame_cnt_d = frame_cnt_q + 1'b1;

        overrun_d = (overrun_q & ~clr_status) | overrun_set;
    end

    // Datapath registers.
    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            win_cnt_q   <= '0;
            acc_q       <= '0;
            tx_frame_q  <= '0;
            frame_cnt_q <= '0;
            overrun_q   <= 1'b0;
        end else begin
            win_cnt_q   <= win_cnt_d;
            acc_q       <= acc_d;
            tx_frame_q  <= tx_frame_d;
            frame_cnt_q <= frame_cnt_d;
            overrun_q   <= overrun_d;
        end
    end

    assign tx_frame  = tx_frame_q;
    assign frame_cnt = frame_cnt_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_frame_sched.sv
// Bench for uart_frame_sched with WIN_CYC=32, TIMEOUT_CYC=64, CNT_W=4.
// A transmitter model answers each uart_start with busy for busy_len cycles
// then a one-cycle uart_done; a scoreboard pops expected frames on uart_start.
module tb_uart_frame_sched;

  logic        clk = 1'b0;
  logic        sys_reset;
  logic        en;
  logic        clr_status;
  logic [17:0] spike_in;
  logic        tx_busy;
  logic        uart_done;
  logic        uart_start;
  logic [17:0] tx_frame;
  logic [3:0]  frame_cnt;
  logic        overrun;
  logic        timeout_err;
  logic [1:0]  sched_state;

  int          n_checks = 0;
  int          n_fail = 0;
  int          start_cnt = 0;
  int          busy_len = 20;
  logic        tx_hang = 1'b0;
  logic        hold_busy = 1'b0;
  logic        model_busy = 1'b0;
  logic        tx_active = 1'b0;
  logic [17:0] exp_q[$];

  assign tx_busy = model_busy | hold_busy;

  uart_frame_sched #(
    .CH_W(18), .WIN_CYC(32), .TIMEOUT_CYC(64), .CNT_W(4)
  ) dut (
    .sys_clk(clk), .sys_reset(sys_reset), .en(en), .clr_status(clr_status),
    .spike_in(spike_in), .tx_busy(tx_busy), .uart_done(uart_done),
    .uart_start(uart_start), .tx_frame(tx_frame), .frame_cnt(frame_cnt),
    .overrun(overrun), .timeout_err(timeout_err), .sched_state(sched_state)
  );

  // clock / global time limit
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish within 20000 cycles");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // transmitter model
  initial begin
    uart_done = 1'b0;
    forever begin
      tick();
      if (uart_start === 1'b1) begin
        tx_active  = 1'b1;
        model_busy = 1'b1;
        ticks(busy_len);
        while (tx_hang) tick();
        uart_done = 1'b1;
        tick();
        uart_done  = 1'b0;
        model_busy = 1'b0;
        tx_active  = 1'b0;
      end
    end
  end

  // scoreboard: every launch pops one expected frame
  initial begin
    logic [17:0] exp;
    forever begin
      tick();
      if (uart_start === 1'b1) begin
        start_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_start: tx_frame=%h, no frame expected", tx_frame);
        end else begin
          exp = exp_q.pop_front();
          if (tx_frame !== exp) begin
            n_fail++;
            $display("FAIL sb_tx_frame: got %h expected %h", tx_frame, exp);
          end
        end
      end
    end
  end

  task automatic do_reset();
    en = 1'b0; spike_in = '0; clr_status = 1'b0; hold_busy = 1'b0; tx_hang = 1'b0;
    for (int k = 0; k < 200 && tx_active; k++) tick();
    sys_reset = 1'b1;
    ticks(2);
    sys_reset = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int k = 0; k < 80 && uart_start !== 1'b1; k++) tick();
    n_checks++;
    if (uart_start !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_start_timeout: uart_start=%b expected 1", name, uart_start);
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 120 && sched_state !== 2'd0; k++) tick();
    n_checks++;
    if (sched_state !== 2'd0) begin
      n_fail++;
      $display("FAIL %s_idle_timeout: sched_state=%0d expected 0", name, sched_state);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL rst_uart_start: got %b expected 0", uart_start); end
    n_checks++; if (tx_frame !== 18'h0) begin n_fail++; $display("FAIL rst_tx_frame: got %h expected 0", tx_frame); end
    n_checks++; if (frame_cnt !== 4'd0) begin n_fail++; $display("FAIL rst_frame_cnt: got %0d expected 0", frame_cnt); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b expected 0", overrun); end
    n_checks++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL rst_timeout_err: got %b expected 0", timeout_err); end
    n_checks++; if (sched_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", sched_state); end
  endtask

  task automatic test_basic_frame();
    do_reset();
    busy_len = 20;
    en = 1'b1;
    tick();                                  // window cycle 0
    n_checks++; if (sched_state !== 2'd1) begin n_fail++; $display("FAIL t1_accum_entry: state=%0d expected 1", sched_state); end
    ticks(3);                                // window cycle 3
    spike_in = 18'h00005; exp_q.push_back(18'h00005);
    tick();
    spike_in = '0;
    ticks(27);                               // window cycle 31 (boundary)
    n_checks++; if (uart_start !== 1'b0) begin n_fail++; $display("FAIL t1_no_early_start: uart_start=%b expected 0", uart_start); end
    tick();                                  // LAUNCH
    n_checks++; if (uart_start !== 1'b1) begin n_fail++; $display("FAIL t1_start_latency: uart_start=%b expected 1", uart_start); end
    n_checks++; if (sched_state !== 2'd2) begin n_fail++; $display("FAIL t1_launch_state: state=%0d expected 2", sched_state); end
    tick();
    n_checks++; if (uart_start !== 1'b0 || sched_state !== 2'd3) begin n_fail++; $display("FAIL t1_wait: uart_start=%b state=%0d expected 0/3", uart_start, sched_state); end
    exp_q.push_back(18'h00000);              // next window carries nothing
    for (int k = 0; k < 40 && frame_cnt !== 4'd1; k++) tick();
    n_checks++; if (frame_cnt !== 4'd1) begin n_fail++; $display("FAIL t1_frame_cnt: got %0d expected 1", frame_cnt); end
    wait_start("t1_second");
    en = 1'b0;
    wait_idle("t1");
  endtask

  task automatic test_overrun();
    do_reset();
    busy_len = 40;
    en = 1'b1;
    tick();                                  // e0
    ticks(5);
    spike_in = 18'h30001; exp_q.push_back(18'h30001);
    tick();
    spike_in = '0;
    ticks(26);                               // e32 = launch rel 0
    n_checks++; if (uart_start !== 1'b1) begin n_fail++; $display("FAIL t2_first_start: uart_start=%b expected 1", uart_start); end
    ticks(10);                               // rel 10, window to be dropped
    spike_in = 18'h00F00;
    tick();
    spike_in = '0;
    ticks(21);                               // rel 32
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL t2_overrun_set: got %b expected 1", overrun); end
    n_checks++; if (sched_state !== 2'd3) begin n_fail++; $display("FAIL t2_still_wait: state=%0d expected 3", sched_state); end
    ticks(18);                               // rel 50, third window
    spike_in = 18'h20000; exp_q.push_back(18'h20000);
    tick();
    spike_in = '0;
    n_checks++; if (frame_cnt !== 4'd1) begin n_fail++; $display("FAIL t2_frame_cnt: got %0d expected 1", frame_cnt); end
    wait_start("t2_third");
    en = 1'b0;
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL t2_overrun_clr: got %b expected 0", overrun); end
    wait_idle("t2");
    n_checks++; if (frame_cnt !== 4'd2) begin n_fail++; $display("FAIL t2_frame_cnt_end: got %0d expected 2", frame_cnt); end
  endtask

  task automatic test_en_drop();
    int sc;
    do_reset();
    busy_len = 20;
    en = 1'b1;
    tick();
    ticks(5);
    spike_in = 18'h00001; exp_q.push_back(18'h00001);
    tick();
    spike_in = '0;
    wait_start("t3");
    tick();                                  // WAIT
    en = 1'b0;
    wait_idle("t3_wait_drop");
    n_checks++; if (frame_cnt !== 4'd1) begin n_fail++; $display("FAIL t3_frame_done: frame_cnt=%0d expected 1", frame_cnt); end
    sc = start_cnt;
    ticks(40);
    n_checks++; if (start_cnt !== sc) begin n_fail++; $display("FAIL t3_no_restart: starts=%0d expected %0d", start_cnt, sc); end
    en = 1'b1;
    tick();                                  // e0
    spike_in = 18'h0000F;
    tick();
    spike_in = '0;
    ticks(30);                               // e31, boundary
    en = 1'b0;
    tick();
    n_checks++; if (sched_state !== 2'd0 || uart_start !== 1'b0) begin n_fail++; $display("FAIL t3_en_vs_boundary: state=%0d uart_start=%b expected 0/0", sched_state, uart_start); end
    ticks(5);
    n_checks++; if (start_cnt !== sc) begin n_fail++; $display("FAIL t3_no_start_after_drop: starts=%0d expected %0d", start_cnt, sc); end
  endtask

  task automatic test_wrap_reset();
    logic [3:0] tgt;
    do_reset();
    busy_len = 4;
    en = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tgt = 4'(i + 1);
      exp_q.push_back(18'h00000);
      for (int k = 0; k < 80 && frame_cnt !== tgt; k++) tick();
      if (i == 14 || i == 15 || i == 16) begin
        n_checks++;
        if (frame_cnt !== tgt) begin n_fail++; $display("FAIL t4_frame_cnt_%0d: got %0d expected %0d", i + 1, frame_cnt, tgt); end
      end
    end
    spike_in = 18'h3FFFF; exp_q.push_back(18'h3FFFF);
    tick();
    spike_in = '0;
    wait_start("t4");
    tick();                                  // WAIT
    n_checks++; if (sched_state !== 2'd3) begin n_fail++; $display("FAIL t4_in_wait: state=%0d expected 3", sched_state); end
    sys_reset = 1'b1;
    en = 1'b0;
    tick();
    sys_reset = 1'b0;
    n_checks++; if (sched_state !== 2'd0 || uart_start !== 1'b0) begin n_fail++; $display("FAIL t4_rst_state: state=%0d uart_start=%b expected 0/0", sched_state, uart_start); end
    n_checks++; if (tx_frame !== 18'h0) begin n_fail++; $display("FAIL t4_rst_tx_frame: got %h expected 0", tx_frame); end
    n_checks++; if (frame_cnt !== 4'd0) begin n_fail++; $display("FAIL t4_rst_frame_cnt: got %0d expected 0", frame_cnt); end
    ticks(10);                               // stale uart_done arrives here
    n_checks++; if (frame_cnt !== 4'd0 || sched_state !== 2'd0) begin n_fail++; $display("FAIL t4_done_ignored: frame_cnt=%0d state=%0d expected 0/0", frame_cnt, sched_state); end
  endtask

  task automatic test_watchdog();
    do_reset();
    busy_len = 20;
    tx_hang = 1'b1;
    en = 1'b1;
    tick();
    ticks(5);
    spike_in = 18'h0C003; exp_q.push_back(18'h0C003);
    tick();
    spike_in = '0;
    wait_start("t5");
    ticks(64);                               // last watchdog cycle
    n_checks++; if (timeout_err !== 1'b0 || sched_state !== 2'd3) begin n_fail++; $display("FAIL t5_before_timeout: timeout_err=%b state=%0d expected 0/3", timeout_err, sched_state); end
    tick();
`ifdef UART_SCHED_WDT_EN
    n_checks++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL t5_timeout_err: got %b expected 1", timeout_err); end
    n_checks++; if (sched_state !== 2'd1 || frame_cnt !== 4'd0) begin n_fail++; $display("FAIL t5_after_timeout: state=%0d frame_cnt=%0d expected 1/0", sched_state, frame_cnt); end
`else
    n_checks++; if (timeout_err !== 1'b0 || sched_state !== 2'd3) begin n_fail++; $display("FAIL t5_no_wdt: timeout_err=%b state=%0d expected 0/3", timeout_err, sched_state); end
    ticks(100);
    n_checks++; if (sched_state !== 2'd3) begin n_fail++; $display("FAIL t5_wait_persists: state=%0d expected 3", sched_state); end
`endif
    en = 1'b0;
    tx_hang = 1'b0;
    wait_idle("t5");
  endtask

  task automatic test_busy_boundary();
    int sc;
    do_reset();
    busy_len = 20;
    en = 1'b1;
    tick();
    ticks(5);
    spike_in = 18'h2AAAA; exp_q.push_back(18'h2AAAA);
    tick();
    spike_in = '0;
    wait_start("t6");                        // rel 0
    ticks(25);                               // rel 25
    n_checks++; if (frame_cnt !== 4'd1) begin n_fail++; $display("FAIL t6_frame_cnt: got %0d expected 1", frame_cnt); end
    sc = start_cnt;
    hold_busy = 1'b1;
    spike_in = 18'h15555;
    tick();
    spike_in = '0;
    ticks(14);                               // rel 40, past busy boundary
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL t6_overrun: got %b expected 1", overrun); end
    n_checks++; if (tx_frame !== 18'h2AAAA) begin n_fail++; $display("FAIL t6_tx_frame_held: got %h expected 2aaaa", tx_frame); end
    n_checks++; if (start_cnt !== sc || sched_state !== 2'd1) begin n_fail++; $display("FAIL t6_no_start: starts=%0d state=%0d expected %0d/1", start_cnt, sched_state, sc); end
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;                       // rel 41
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL t6_clr: overrun=%b expected 0", overrun); end
    ticks(22);                               // rel 63, boundary with busy
    clr_status = 1'b1;
    tick();
    clr_status = 1'b0;
    n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL t6_set_beats_clr: overrun=%b expected 1", overrun); end
    en = 1'b0;
    hold_busy = 1'b0;
    tick();
    n_checks++; if (sched_state !== 2'd0 || start_cnt !== sc) begin n_fail++; $display("FAIL t6_end: state=%0d starts=%0d expected 0/%0d", sched_state, start_cnt, sc); end
  endtask

  initial begin
    sys_reset = 1'b1; en = 1'b0; clr_status = 1'b0; spike_in = '0;
    test_reset();
    test_basic_frame();
    test_overrun();
    test_en_drop();
    test_wrap_reset();
    test_watchdog();
    test_busy_boundary();
    ticks(5);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d expected frames never launched, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
